keypad_scan_ctrl: RTL

Scan controller for the 4x4 matrix keypad and 4-digit multiplexed 7-segment display. Strobes keypad rows one at a time, debounces column returns, and emits one validated key code per press. Accepted keys shift into a 4-digit display buffer, which is time-multiplexed onto the shared segment lines. Sits between the board keypad and LED pins, replacing the fixed single-row, single-digit drive.

---
 rtl/keypad_pkg.sv | 19 +
 rtl/seg7_decode.sv | 11 +
 rtl/keypad_scan_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner and 7-segment display driver.
package keypad_pkg;

  localparam int unsigned NUM_LINES = 4;
  localparam int unsigned IDX_W     = 2;

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HELD     = 2'd2
  } state_t;

  // Active-high {a..g} patterns; entry 0 sits in the low bits.
  localparam logic [15:0][6:0] SEG_HI = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

endpackage

// File: rtl/seg7_decode.sv
// Hex digit to active-low {a..g} segment decoder, purely combinational.
module seg7_decode
  import keypad_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg_c
);

  assign seg_c = ~SEG_HI[value];

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad row scanner with tick-based debounce, feeding a 4-digit
// shift buffer that is time-multiplexed onto a shared 7-segment bus.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned DEBOUNCE    = 4,
  parameter int unsigned REFRESH_DIV = 100000
)(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] en,
  output logic [6:0] seg,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
  localparam int unsigned REF_W  = $clog2(REFRESH_DIV);
  localparam int unsigned DEB_W  = $clog2(DEBOUNCE + 1);

  logic [3:0]           col_meta;
  logic [3:0]           col_sync;
  logic [SCAN_W-1:0]    scan_cnt;
  logic                 scan_tick_c;
  logic [REF_W-1:0]     refresh_cnt;
  logic                 refresh_adv_c;

  state_t               state, state_n;
  logic [IDX_W-1:0]     r, r_n;
  logic [IDX_W-1:0]     c, c_n;
  logic [DEB_W-1:0]     deb_cnt, deb_n;
  logic [DEB_W-1:0]     rel_cnt, rel_n;
  logic                 accept_c;

  logic                 single_c;
  logic [IDX_W-1:0]     col_idx_c;

  logic [3:0][3:0]      digits, digits_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [3:0]           code_c;
  logic [6:0]           seg_n;

  // Two-flop synchronizer for the asynchronous column returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      col_meta <= col;
      col_sync <= col_meta;
    end
  end

  assign scan_tick_c   = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign refresh_adv_c = (refresh_cnt == REF_W'(REFRESH_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt    <= '0;
      refresh_cnt <= '0;
    end else begin
      scan_cnt    <= scan_tick_c ? '0 : scan_cnt + SCAN_W'(1);
      refresh_cnt <= refresh_adv_c ? '0 : refresh_cnt + REF_W'(1);
    end
  end

  // Exactly one low column is a key; anything else is treated as no key.
  always_comb begin
    single_c  = 1'b1;
    col_idx_c = 2'd0;
    case (col_sync)
      4'b1110: col_idx_c = 2'd0;
      4'b1101: col_idx_c = 2'd1;
      4'b1011: col_idx_c = 2'd2;
      4'b0111: col_idx_c = 2'd3;
      default: single_c  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_SCAN;
      r       <= '0;
      c       <= '0;
      deb_cnt <= '0;
      rel_cnt <= '0;
    end else begin
      state   <= state_n;
      r       <= r_n;
      c       <= c_n;
      deb_cnt <= deb_n;
      rel_cnt <= rel_n;
    end
  end

  always_comb begin
    state_n  = state;
    r_n      = r;
    c_n      = c;
    deb_n    = deb_cnt;
    rel_n    = rel_cnt;
    accept_c = 1'b0;
    if (scan_tick_c) begin
      case (state)
        S_SCAN: begin
          if (single_c) begin
            c_n     = col_idx_c;
            deb_n   = '0;
            state_n = S_DEBOUNCE;
          end else begin
            r_n = r + 2'd1;
          end
        end
        S_DEBOUNCE: begin
          if (single_c && (col_idx_c == c)) begin
            deb_n = deb_cnt + DEB_W'(1);
            if (deb_n == DEB_W'(DEBOUNCE)) begin
              accept_c = 1'b1;
              rel_n    = '0;
              state_n  = S_HELD;
            end
          end else begin
            state_n = S_SCAN;
            r_n     = r + 2'd1;
          end
        end
        S_HELD: begin
          rel_n = (col_sync == 4'hF) ? rel_cnt + DEB_W'(1) : '0;
          if (rel_n == DEB_W'(DEBOUNCE)) begin
            state_n = S_SCAN;
            r_n     = r + 2'd1;
          end
        end
        default: state_n = S_SCAN;
      endcase
    end
  end

  // Key code 4*r + c; next-digit data feeds the segment register so an
  // accept and a digit advance in the same cycle are both visible at once.
  assign code_c   = {r, c};
  assign digits_n = accept_c ? {digits[2:0], code_c} : digits;
  assign idx_n    = refresh_adv_c ? idx + 2'd1 : idx;

  seg7_decode u_seg7_decode (
    .value (digits_n[idx_n]),
    .seg_c (seg_n)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row       <= 4'b1110;
      en        <= 4'b1110;
      seg       <= 7'b0000001;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      digits    <= '0;
      idx       <= '0;
    end else begin
      row       <= ~(4'b0001 << r_n);
      en        <= ~(4'b0001 << idx_n);
      seg       <= seg_n;
      key_valid <= accept_c;
      if (accept_c) key_code <= code_c;
      digits    <= digits_n;
      idx       <= idx_n;
    end
  end

endmodule
